// File: rtl/same_idx_seq.sv
// same_idx_seq: index sequencer for a same-size convolution.
// On start it latches sizeX/sizeY, publishes init_same = floor(sizeY/2) to the
// pointer stage and then walks i = 0..sizeX-1. For each i it presents the
// full-convolution index k = init_same + i and the valid Y-tap range
// [jmin, jmax].
//
// Handshake: idx_valid_o / idx_ready_i follow strict valid/ready rules. A
// transfer happens on a rising edge where both are high. Once idx_valid_o is
// raised, it and the triple hold unchanged until that transfer. idx_valid_o
// never depends on idx_ready_i.
module same_idx_seq #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             start_i,
  input  logic [IDX_W-1:0] size_x_i,
  input  logic [IDX_W-1:0] size_y_i,
  output logic [IDX_W-1:0] init_same_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [IDX_W-1:0] k_o,
  output logic [IDX_W-1:0] jmin_o,
  output logic [IDX_W-1:0] jmax_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       state_o
);

  localparam int EW = IDX_W + 1;
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(32);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_EMIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] size_x_r, size_y_r, i_r, init_r;
  logic [IDX_W-1:0] k_r, jmin_r, jmax_r;
  logic             valid_r, err_r;

  logic             size_bad, handshake, last, load;
  logic [IDX_W-1:0] sel_i;
  logic [EW-1:0]    k_w, xm1, ym1, jmin_w, jmax_w;
  logic [EW:0]      diff;
  logic             unused_bits;

  // Triple for the index about to be presented: the current i on the first
  // load of the run, i+1 when advancing after a transfer.
  always_comb begin
    size_bad  = (size_x_r == '0) || (size_x_r > MAX_LEN) ||
                (size_y_r == '0) || (size_y_r > MAX_LEN);
    handshake = valid_r & idx_ready_i;
    last      = (i_r == (size_x_r - ONE));
    load      = (state == S_EMIT) & (~valid_r | (handshake & ~last));
    sel_i     = valid_r ? (i_r + ONE) : i_r;
    k_w       = {1'b0, init_r} + {1'b0, sel_i};
    xm1       = {1'b0, size_x_r} - EW'(1);
    ym1       = {1'b0, size_y_r} - EW'(1);
    // Signed difference: a negative k-(sizeX-1) clamps jmin to 0.
    diff      = $signed({1'b0, k_w}) - $signed({1'b0, xm1});
    jmin_w    = diff[EW] ? '0 : diff[EW-1:0];
    jmax_w    = (k_w < ym1) ? k_w : ym1;
    unused_bits = jmin_w[EW-1] ^ jmax_w[EW-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_INIT;
      S_INIT:  state_nxt = size_bad ? S_DONE : S_EMIT;
      S_EMIT:  if (handshake && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_o  = (state == S_INIT) || (state == S_EMIT);
    done_o  = (state == S_DONE);
    state_o = state;
  end

  // Size capture, window offset, walk counter, valid and sticky error.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      size_x_r <= '0;
      size_y_r <= '0;
      init_r   <= '0;
      i_r      <= '0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          size_x_r <= size_x_i;
          size_y_r <= size_y_i;
          err_r    <= 1'b0;
        end
        S_INIT: begin
          init_r <= size_y_r >> 1;
          i_r    <= '0;
          err_r  <= size_bad;
        end
        S_EMIT: begin
          if (!valid_r) valid_r <= 1'b1;
          else if (handshake) begin
            if (last) valid_r <= 1'b0;
            else      i_r     <= i_r + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output triple registers; they keep their last values after a run.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      k_r    <= '0;
      jmin_r <= '0;
      jmax_r <= '0;
    end else if (load) begin
      k_r    <= k_w[IDX_W-1:0];
      jmin_r <= jmin_w[IDX_W-1:0];
      jmax_r <= jmax_w[IDX_W-1:0];
    end
  end

  assign init_same_o = init_r;
  assign idx_valid_o = valid_r;
  assign k_o         = k_r;
  assign jmin_o      = jmin_r;
  assign jmax_o      = jmax_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_same_idx_seq.sv
// Bench for same_idx_seq: directed runs push hand-computed triples into a
// queue; a negedge monitor pops and compares on every transfer.
module tb_same_idx_seq;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       start_i;
  logic [5:0] size_x_i, size_y_i;
  logic [5:0] init_same_o;
  logic       idx_valid_o, idx_ready_i;
  logic [5:0] k_o, jmin_o, jmax_o;
  logic       busy_o, done_o, err_o;
  logic [1:0] state_o;

  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int h0, d0, n, cyc;

  same_idx_seq #(.IDX_W(6)) dut (
    .clk(clk), .rst_a(rst_a), .start_i(start_i),
    .size_x_i(size_x_i), .size_y_i(size_y_i), .init_same_o(init_same_o),
    .idx_valid_o(idx_valid_o), .idx_ready_i(idx_ready_i),
    .k_o(k_o), .jmin_o(jmin_o), .jmax_o(jmax_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  // Clock.
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_a) begin
      if (idx_valid_o && idx_ready_i) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL triple_unexpected: got k=%0d jmin=%0d jmax=%0d, required none", k_o, jmin_o, jmax_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({k_o, jmin_o, jmax_o} !== mon_e) begin
            bad++;
            $display("FAIL triple: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     k_o, jmin_o, jmax_o, mon_e[17:12], mon_e[11:6], mon_e[5:0]);
          end
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int jmin, input int jmax);
    exp_q.push_back({6'(k), 6'(jmin), 6'(jmax)});
  endtask

  task automatic push_5x3();
    push(1, 0, 1); push(2, 0, 2); push(3, 0, 2); push(4, 0, 2); push(5, 1, 2);
  endtask

  task automatic start_run(input logic [5:0] sx, input logic [5:0] sy);
    size_x_i = sx;
    size_y_i = sy;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done_o && c < budget) begin
      tick();
      c++;
    end
    check("done_seen", done_o, 1);
  endtask

  initial begin
    rst_a = 1'b0; start_i = 1'b0; size_x_i = '0; size_y_i = '0; idx_ready_i = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {init_same_o, idx_valid_o, k_o, jmin_o, jmax_o, busy_o, done_o, err_o}, 0);
    check("reset_state", state_o, 0);
    rst_a = 1'b1;
    tick();

    // Basic run 5x3 with ready held high.
    push_5x3();
    h0 = hs_cnt;
    idx_ready_i = 1'b1;
    start_run(5, 3);
    check("valid_t0", idx_valid_o, 0);
    tick();
    check("valid_t1", idx_valid_o, 0);
    check("init_same_before_valid", init_same_o, 1);
    tick();
    check("valid_t2", idx_valid_o, 1);
    n = 0;
    while (idx_valid_o && n < 40) begin
      n++;
      tick();
    end
    check("valid_cycles_5x3", n, 5);
    check("done_after_last", done_o, 1);
    check("busy_in_done", busy_o, 0);
    tick();
    check("done_one_cycle", done_o, 0);
    check("hs_5x3", hs_cnt - h0, 5);
    check("queue_empty_5x3", exp_q.size(), 0);

    // Extreme 1x1.
    push(0, 0, 0);
    h0 = hs_cnt;
    start_run(1, 1);
    wait_done(20, cyc);
    check("init_same_1x1", init_same_o, 0);
    check("hs_1x1", hs_cnt - h0, 1);
    tick();
    check("done_low_1x1", done_o, 0);

    // Extreme 32x32.
    push(16, 0, 16);
    for (int i = 1; i < 31; i++) begin
      int k;
      k = 16 + i;
      push(k, (k > 31) ? k - 31 : 0, (k < 31) ? k : 31);
    end
    push(47, 16, 31);
    h0 = hs_cnt;
    start_run(32, 32);
    wait_done(100, cyc);
    check("init_same_32x32", init_same_o, 16);
    check("hs_32x32", hs_cnt - h0, 32);
    check("last_k_kept", {k_o, jmin_o, jmax_o}, {6'd47, 6'd16, 6'd31});
    tick();

    // Backpressure on the 2nd triple for 3 cycles.
    push_5x3();
    h0 = hs_cnt;
    start_run(5, 3);
    tick();
    tick();
    tick();
    idx_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("hold_2nd_triple", {idx_valid_o, k_o, jmin_o, jmax_o}, {1'b1, 6'd2, 6'd0, 6'd2});
      if (c < 3) tick();
    end
    idx_ready_i = 1'b1;
    wait_done(40, cyc);
    check("hs_backpressure", hs_cnt - h0, 5);
    tick();

    // Error run: sizeX = 0.
    h0 = hs_cnt;
    start_run(0, 3);
    check("err_done_early", done_o, 0);
    tick();
    check("err_done", done_o, 1);
    check("err_set", err_o, 1);
    check("err_no_valid", idx_valid_o, 0);
    tick();
    check("err_done_low", done_o, 0);
    check("err_sticky", err_o, 1);
    check("err_idle", busy_o, 0);
    check("err_hs", hs_cnt - h0, 0);

    // Valid start clears err; a start pulse during EMIT is ignored.
    push_5x3();
    h0 = hs_cnt;
    start_run(5, 3);
    check("err_cleared", err_o, 0);
    tick();
    tick();
    tick();
    size_x_i = 2;
    size_y_i = 7;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    wait_done(40, cyc);
    check("ignored_start_hs", hs_cnt - h0, 5);
    check("ignored_start_init", init_same_o, 1);
    tick();
    check("ignored_start_no_rerun", busy_o, 0);

    // Reset during EMIT at i=2.
    push_5x3();
    start_run(5, 3);
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_k", k_o, 3);
    d0 = done_cnt;
    rst_a = 1'b0;
    #1;
    check("async_reset_outputs", {init_same_o, idx_valid_o, k_o, jmin_o, jmax_o, busy_o, done_o, err_o}, 0);
    exp_q.delete();
    tick();
    tick();
    check("reset_no_done", done_cnt - d0, 0);
    rst_a = 1'b1;
    tick();
    push_5x3();
    h0 = hs_cnt;
    start_run(5, 3);
    wait_done(40, cyc);
    check("post_reset_hs", hs_cnt - h0, 5);
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
